// File: rtl/branch_predictor.sv
// BTB plus saturating-counter direction predictor: zero-latency IF-stage lookup, MEM-stage training.
// Optional gshare counter indexing is enabled by defining BRANCH_PREDICTOR_GSHARE_EN.
module branch_predictor #(
    parameter int unsigned ENTRIES = 16,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned CNT_W   = 2,
    parameter int unsigned STAT_W  = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] pred_pc_i,
    output logic              pred_hit_o,
    output logic              pred_taken_o,
    output logic [ADDR_W-1:0] pred_target_o,
    input  logic              upd_valid_i,
    input  logic [ADDR_W-1:0] upd_pc_i,
    input  logic              upd_taken_i,
    input  logic [ADDR_W-1:0] upd_target_i,
    input  logic              upd_pred_taken_i,
    input  logic [ADDR_W-1:0] upd_pred_target_i,
    input  logic              flush_i,
    output logic [STAT_W-1:0] branch_cnt_o,
    output logic [STAT_W-1:0] mispred_cnt_o
);

    localparam int unsigned IDX_W = $clog2(ENTRIES);
    localparam int unsigned TAG_W = ADDR_W - IDX_W - 2;

    localparam logic [CNT_W-1:0] CntMax    = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CntWeakT  = CNT_W'(1) << (CNT_W - 1);
    localparam logic [CNT_W-1:0] CntWeakNt = CntWeakT - CNT_W'(1);

    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [ADDR_W-1:0]  target_q [ENTRIES];
    logic [CNT_W-1:0]   cnt_q    [ENTRIES];
    logic [STAT_W-1:0]  branch_cnt_q;
    logic [STAT_W-1:0]  mispred_cnt_q;

    logic [IDX_W-1:0] pred_idx;
    logic [IDX_W-1:0] pred_cidx;
    logic [TAG_W-1:0] pred_tag;
    logic [IDX_W-1:0] upd_idx;
    logic [IDX_W-1:0] upd_cidx;
    logic [TAG_W-1:0] upd_tag;

    logic             upd_accept;
    logic             upd_hit;
    logic             alloc;
    logic             tgt_wr;
    logic             cnt_wr;
    logic [CNT_W-1:0] cnt_cur;
    logic [CNT_W-1:0] cnt_new;
    logic             mispred;

    logic unused_pc_bits;
    assign unused_pc_bits = ^{pred_pc_i[1:0], upd_pc_i[1:0]};

    assign pred_idx   = pred_pc_i[IDX_W+1:2];
    assign pred_tag   = pred_pc_i[ADDR_W-1:IDX_W+2];
    assign upd_idx    = upd_pc_i[IDX_W+1:2];
    assign upd_tag    = upd_pc_i[ADDR_W-1:IDX_W+2];
    assign upd_accept = upd_valid_i && !flush_i;

`ifdef BRANCH_PREDICTOR_GSHARE_EN
    logic [IDX_W-1:0] ghr_q;
    logic [IDX_W-1:0] ghr_d;

    // Counters are history-hashed; valid/tag/target stay PC-indexed.
    assign pred_cidx = pred_idx ^ ghr_q;
    assign upd_cidx  = upd_idx ^ ghr_q;

    always_comb begin
        ghr_d = ghr_q;
        if (flush_i) begin
            ghr_d = '0;
        end else if (upd_valid_i) begin
            ghr_d = IDX_W'({ghr_q, upd_taken_i});
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ghr_q <= '0;
        end else begin
            ghr_q <= ghr_d;
        end
    end
`else
    assign pred_cidx = pred_idx;
    assign upd_cidx  = upd_idx;
`endif

    // Lookup sees registered contents only; an update in the same cycle shows up after the edge.
    always_comb begin
        pred_hit_o    = valid_q[pred_idx] && (tag_q[pred_idx] == pred_tag);
        pred_taken_o  = pred_hit_o && cnt_q[pred_cidx][CNT_W-1];
        pred_target_o = pred_taken_o ? target_q[pred_idx] : pred_pc_i + ADDR_W'(4);
    end

    always_comb begin
        upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
        cnt_cur = cnt_q[upd_cidx];
        cnt_new = cnt_cur;
        alloc   = 1'b0;
        tgt_wr  = 1'b0;
        cnt_wr  = 1'b0;
        if (upd_accept) begin
            if (upd_hit) begin
                cnt_wr = 1'b1;
                if (upd_taken_i) begin
                    tgt_wr  = 1'b1;
                    cnt_new = (cnt_cur == CntMax) ? cnt_cur : cnt_cur + CNT_W'(1);
                end else begin
                    cnt_new = (cnt_cur == '0) ? cnt_cur : cnt_cur - CNT_W'(1);
                end
            end else if (upd_taken_i) begin
                alloc   = 1'b1;
                tgt_wr  = 1'b1;
                cnt_wr  = 1'b1;
                cnt_new = CntWeakT;
            end
        end
    end

    assign mispred = (upd_pred_taken_i != upd_taken_i) ||
                     (upd_taken_i && (upd_pred_target_i != upd_target_i));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= '0;
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                cnt_q[i]    <= CntWeakNt;
            end
        end else if (flush_i) begin
            valid_q <= '0;
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                cnt_q[i] <= CntWeakNt;
            end
        end else begin
            if (alloc) begin
                valid_q[upd_idx] <= 1'b1;
                tag_q[upd_idx]   <= upd_tag;
            end
            if (tgt_wr) begin
                target_q[upd_idx] <= upd_target_i;
            end
            if (cnt_wr) begin
                cnt_q[upd_cidx] <= cnt_new;
            end
        end
    end

    // Statistics count every resolved branch, flush or not, and stick at all-ones.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else if (upd_valid_i) begin
            if (branch_cnt_q != {STAT_W{1'b1}}) begin
                branch_cnt_q <= branch_cnt_q + STAT_W'(1);
            end
            if (mispred && (mispred_cnt_q != {STAT_W{1'b1}})) begin
                mispred_cnt_q <= mispred_cnt_q + STAT_W'(1);
            end
        end
    end

    assign branch_cnt_o  = branch_cnt_q;
    assign mispred_cnt_o = mispred_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed, table-driven bench for branch_predictor; a second instance with 2-bit
// statistics checks counter saturation.
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pred_pc;
    logic        pred_hit, pred_taken;
    logic [31:0] pred_target;
    logic        upd_valid, upd_taken, upd_pred_taken, flush;
    logic [31:0] upd_pc, upd_target, upd_pred_target;
    logic [31:0] branch_cnt, mispred_cnt;
    logic        s_hit, s_taken;
    logic [31:0] s_target;
    logic [1:0]  s_branch_cnt, s_mispred_cnt;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    branch_predictor dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .pred_pc_i        (pred_pc),
        .pred_hit_o       (pred_hit),
        .pred_taken_o     (pred_taken),
        .pred_target_o    (pred_target),
        .upd_valid_i      (upd_valid),
        .upd_pc_i         (upd_pc),
        .upd_taken_i      (upd_taken),
        .upd_target_i     (upd_target),
        .upd_pred_taken_i (upd_pred_taken),
        .upd_pred_target_i(upd_pred_target),
        .flush_i          (flush),
        .branch_cnt_o     (branch_cnt),
        .mispred_cnt_o    (mispred_cnt)
    );

    branch_predictor #(.STAT_W(2)) dut_sat (
        .clk_i            (clk),
        .rst_i            (rst),
        .pred_pc_i        (pred_pc),
        .pred_hit_o       (s_hit),
        .pred_taken_o     (s_taken),
        .pred_target_o    (s_target),
        .upd_valid_i      (upd_valid),
        .upd_pc_i         (upd_pc),
        .upd_taken_i      (upd_taken),
        .upd_target_i     (upd_target),
        .upd_pred_taken_i (upd_pred_taken),
        .upd_pred_target_i(upd_pred_target),
        .flush_i          (flush),
        .branch_cnt_o     (s_branch_cnt),
        .mispred_cnt_o    (s_mispred_cnt)
    );

    typedef struct {
        logic        uv;
        logic [31:0] upc;
        logic        ut;
        logic [31:0] utgt;
        logic        upt;
        logic [31:0] uptgt;
        logic        fl;
        logic [31:0] lpc;
        logic        e_hit;
        logic        e_taken;
        logic [31:0] e_tgt;
        int          e_bc;
        int          e_mc;
    } vec_t;

    localparam int NVEC = 21;
    vec_t vecs[NVEC];

    function automatic vec_t mk(logic uv, logic [31:0] upc, logic ut, logic [31:0] utgt,
                                logic upt, logic [31:0] uptgt, logic fl, logic [31:0] lpc,
                                logic eh, logic et, logic [31:0] etgt, int bc, int mc);
        vec_t v;
        v.uv = uv; v.upc = upc; v.ut = ut; v.utgt = utgt; v.upt = upt; v.uptgt = uptgt;
        v.fl = fl; v.lpc = lpc; v.e_hit = eh; v.e_taken = et; v.e_tgt = etgt;
        v.e_bc = bc; v.e_mc = mc;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0;
        upd_pred_taken = 1'b0; upd_pred_target = '0; flush = 1'b0;
    endtask

`ifdef BRANCH_PREDICTOR_GSHARE_EN
    task automatic gs_upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
        upd_valid = 1'b1; upd_pc = pc; upd_taken = tk; upd_target = tgt;
        upd_pred_taken = 1'b0; upd_pred_target = pc + 32'd4;
        step();
        idle_inputs();
    endtask
`endif

    initial begin
        rst = 1'b1;
        pred_pc = 32'h40;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

`ifdef BRANCH_PREDICTOR_GSHARE_EN
        // T, N, T: counters touched at 0, 1, 2; history then 0101 so the next update uses idx 5.
        gs_upd(32'h40, 1'b1, 32'h100);
        gs_upd(32'h40, 1'b0, 32'h100);
        gs_upd(32'h40, 1'b1, 32'h100);
        check("gs_ghr_after3", 64'(dut.ghr_q), 64'h5);
        check("gs_cnt0", 64'(dut.cnt_q[0]), 64'h2);
        check("gs_cnt1", 64'(dut.cnt_q[1]), 64'h0);
        check("gs_cnt2", 64'(dut.cnt_q[2]), 64'h2);
        @(negedge clk);
        check("gs_hit", 64'(pred_hit), 64'h1);
        check("gs_taken_idx5", 64'(pred_taken), 64'h0);
        check("gs_target", 64'(pred_target), 64'h44);
        step();
        gs_upd(32'h40, 1'b0, 32'h100);
        check("gs_cnt5", 64'(dut.cnt_q[5]), 64'h0);
        check("gs_ghr_after4", 64'(dut.ghr_q), 64'ha);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("gs_ghr_flush", 64'(dut.ghr_q), 64'h0);
        check("gs_cnt0_flush", 64'(dut.cnt_q[0]), 64'h1);
        @(negedge clk);
        check("gs_hit_flush", 64'(pred_hit), 64'h0);
        check("gs_bc", 64'(branch_cnt), 64'd4);
`else
        //            uv upc     ut utgt     upt uptgt   fl lpc          hit tk tgt          bc  mc
        vecs[0]  = mk(0, 32'h0,  0, 32'h0,   0, 32'h0,   0, 32'h40,      0, 0, 32'h44,  0,  0);
        vecs[1]  = mk(1, 32'h40, 1, 32'h100, 0, 32'h44,  0, 32'h40,      0, 0, 32'h44,  0,  0);
        vecs[2]  = mk(1, 32'h40, 0, 32'h100, 1, 32'h100, 0, 32'h40,      1, 1, 32'h100, 1,  1);
        vecs[3]  = mk(1, 32'h40, 0, 32'h100, 0, 32'h44,  0, 32'h40,      1, 0, 32'h44,  2,  2);
        vecs[4]  = mk(1, 32'h40, 0, 32'h100, 0, 32'h44,  0, 32'h40,      1, 0, 32'h44,  3,  2);
        vecs[5]  = mk(1, 32'h40, 1, 32'h100, 0, 32'h44,  0, 32'h40,      1, 0, 32'h44,  4,  2);
        vecs[6]  = mk(1, 32'h40, 1, 32'h100, 0, 32'h44,  0, 32'h40,      1, 0, 32'h44,  5,  3);
        vecs[7]  = mk(1, 32'h40, 1, 32'h100, 1, 32'h100, 0, 32'h40,      1, 1, 32'h100, 6,  4);
        vecs[8]  = mk(1, 32'h40, 1, 32'h100, 1, 32'h100, 0, 32'h40,      1, 1, 32'h100, 7,  4);
        vecs[9]  = mk(1, 32'h40, 0, 32'h100, 1, 32'h100, 0, 32'h40,      1, 1, 32'h100, 8,  4);
        vecs[10] = mk(1, 32'h40, 1, 32'h180, 1, 32'h100, 0, 32'h40,      1, 1, 32'h100, 9,  5);
        vecs[11] = mk(1, 32'h80, 1, 32'h200, 0, 32'h84,  0, 32'h40,      1, 1, 32'h180, 10, 6);
        vecs[12] = mk(0, 32'h0,  0, 32'h0,   0, 32'h0,   0, 32'h40,      0, 0, 32'h44,  11, 7);
        vecs[13] = mk(1, 32'h44, 0, 32'h400, 0, 32'h48,  0, 32'h80,      1, 1, 32'h200, 11, 7);
        vecs[14] = mk(0, 32'h0,  0, 32'h0,   0, 32'h0,   0, 32'h44,      0, 0, 32'h48,  12, 7);
        vecs[15] = mk(1, 32'h44, 1, 32'h300, 0, 32'h48,  1, 32'h80,      1, 1, 32'h200, 12, 7);
        vecs[16] = mk(0, 32'h0,  0, 32'h0,   0, 32'h0,   0, 32'h80,      0, 0, 32'h84,  13, 8);
        vecs[17] = mk(0, 32'h0,  0, 32'h0,   0, 32'h0,   0, 32'h44,      0, 0, 32'h48,  13, 8);
        vecs[18] = mk(1, 32'h80, 1, 32'h200, 0, 32'h84,  0, 32'h80,      0, 0, 32'h84,  13, 8);
        vecs[19] = mk(0, 32'h0,  0, 32'h0,   0, 32'h0,   0, 32'h80,      1, 1, 32'h200, 14, 9);
        vecs[20] = mk(0, 32'h0,  0, 32'h0,   0, 32'h0,   0, 32'hfffffffc, 0, 0, 32'h0,  14, 9);

        // Each row's checks see state from all earlier rows; its own update lands at the next edge.
        for (int i = 0; i < NVEC; i++) begin
            upd_valid = vecs[i].uv; upd_pc = vecs[i].upc; upd_taken = vecs[i].ut;
            upd_target = vecs[i].utgt; upd_pred_taken = vecs[i].upt;
            upd_pred_target = vecs[i].uptgt; flush = vecs[i].fl; pred_pc = vecs[i].lpc;
            @(negedge clk);
            check($sformatf("v%0d_hit", i), 64'(pred_hit), 64'(vecs[i].e_hit));
            check($sformatf("v%0d_taken", i), 64'(pred_taken), 64'(vecs[i].e_taken));
            check($sformatf("v%0d_target", i), 64'(pred_target), 64'(vecs[i].e_tgt));
            check($sformatf("v%0d_bcnt", i), 64'(branch_cnt), 64'(vecs[i].e_bc));
            check($sformatf("v%0d_mcnt", i), 64'(mispred_cnt), 64'(vecs[i].e_mc));
            check($sformatf("v%0d_sat_bcnt", i), 64'(s_branch_cnt),
                  64'((vecs[i].e_bc > 3) ? 3 : vecs[i].e_bc));
            check($sformatf("v%0d_sat_mcnt", i), 64'(s_mispred_cnt),
                  64'((vecs[i].e_mc > 3) ? 3 : vecs[i].e_mc));
            step();
        end

        // Reset coinciding with an allocating update: the update must be dropped.
        rst = 1'b1;
        upd_valid = 1'b1; upd_pc = 32'h40; upd_taken = 1'b1; upd_target = 32'h100;
        upd_pred_taken = 1'b0; upd_pred_target = 32'h44;
        step();
        rst = 1'b0;
        idle_inputs();
        pred_pc = 32'h40;
        @(negedge clk);
        check("rst_upd_hit40", 64'(pred_hit), 64'h0);
        check("rst_upd_target40", 64'(pred_target), 64'h44);
        check("rst_bcnt", 64'(branch_cnt), 64'h0);
        check("rst_mcnt", 64'(mispred_cnt), 64'h0);
        check("rst_sat_bcnt", 64'(s_branch_cnt), 64'h0);
        pred_pc = 32'h80;
        #1;
        check("rst_hit80", 64'(pred_hit), 64'h0);
        check("rst_target80", 64'(pred_target), 64'h84);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
